// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
package mux4_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

endpackage

// File: rtl/mux4_next_ch.sv
// Finds the next higher enabled channel above i_ch, or the lowest enabled
// channel when i_none is set. o_last flags that no such channel exists.
module mux4_next_ch
  import mux4_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_ch,
  input  logic              i_none,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_last
);

  // Scan downwards so the final hit is the lowest qualifying channel.
  always_comb begin
    o_ch   = '0;
    o_last = 1'b1;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (i_mask[k] && (i_none || (k > int'(i_ch)))) begin
        o_ch   = k[CH_W-1:0];
        o_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer around a 4:1 mux: steps the selects over enabled channels,
// dwells DWELL cycles on each, captures y and publishes a per-frame snapshot.
//
// state | meaning
// IDLE  | selects parked at 00, waiting for start
// SCAN  | frame in progress, dwelling on / capturing the current channel
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              y,
  output logic              s0,
  output logic              s1,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample
);

  localparam int                CNT_W    = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t            r_state,  w_state;
  logic [NUM_CH-1:0] r_mask,   w_mask;
  logic [CH_W-1:0]   r_ch,     w_ch;
  logic [CNT_W-1:0]  r_cnt,    w_cnt;
  logic [NUM_CH-1:0] r_shadow, w_shadow;
  logic              r_cont,   w_cont;
  logic              r_stop,   w_stop;
  logic              r_done,   w_done;
  logic [NUM_CH-1:0] r_sample, w_sample;

  logic [NUM_CH-1:0] w_cap;
  logic              w_stop_pend;
  logic [CH_W-1:0]   w_next_ch;
  logic              w_last;
  logic [CH_W-1:0]   w_first_ch;
  logic              w_none;

  mux4_next_ch u_next (
    .i_mask (r_mask),
    .i_ch   (r_ch),
    .i_none (1'b0),
    .o_ch   (w_next_ch),
    .o_last (w_last)
  );

  // First-channel lookup on the live mask, used at frame start and restart.
  mux4_next_ch u_first (
    .i_mask (ch_mask),
    .i_ch   ('0),
    .i_none (1'b1),
    .o_ch   (w_first_ch),
    .o_last (w_none)
  );

  always_comb begin
    w_state     = r_state;
    w_mask      = r_mask;
    w_ch        = r_ch;
    w_cnt       = r_cnt;
    w_shadow    = r_shadow;
    w_cont      = r_cont;
    w_stop      = r_stop;
    w_done      = 1'b0;
    w_sample    = r_sample;
    w_cap       = r_shadow;
    w_stop_pend = r_stop | stop;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (!w_none) begin
            w_state  = SCAN;
            w_mask   = ch_mask;
            w_cont   = cont;
            w_ch     = w_first_ch;
            w_cnt    = '0;
            w_shadow = '0;
          end else begin
            w_done   = 1'b1;
            w_sample = '0;
          end
        end
      end

      SCAN: begin
        w_stop = w_stop_pend;
        if (r_cnt == CNT_LAST) begin
          w_cnt       = '0;
          w_cap[r_ch] = y;
          if (w_last) begin
            w_sample = w_cap & r_mask;
            w_done   = 1'b1;
            w_shadow = '0;
            if (r_cont && !w_stop_pend && !w_none) begin
              w_mask = ch_mask;
              w_ch   = w_first_ch;
            end else begin
              w_state = IDLE;
              w_ch    = '0;
              w_stop  = 1'b0;
            end
          end else begin
            w_shadow = w_cap;
            w_ch     = w_next_ch;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_ch     <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_cont   <= 1'b0;
      r_stop   <= 1'b0;
      r_done   <= 1'b0;
      r_sample <= '0;
    end else begin
      r_state  <= w_state;
      r_mask   <= w_mask;
      r_ch     <= w_ch;
      r_cnt    <= w_cnt;
      r_shadow <= w_shadow;
      r_cont   <= w_cont;
      r_stop   <= w_stop;
      r_done   <= w_done;
      r_sample <= w_sample;
    end
  end

  assign s1     = r_ch[1];
  assign s0     = r_ch[0];
  assign busy   = (r_state == SCAN);
  assign done   = r_done;
  assign sample = r_sample;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: three instances with different dwell times share
// stimulus and are checked every cycle against a frame-schedule model.
module tb_mux4_scan_ctrl;

  localparam int NL = 3;

  function automatic int dw_of(input int l);
    return (l == 0) ? 2 : (l == 1) ? 1 : 3;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] ch_mask = 4'h0;
  logic       y_rand = 1'b0;
  int         y_mode = 0;   // 0 random, 1 constant one, 2 parity of selected channel

  logic [NL-1:0] s0_a, s1_a, busy_a, done_a, y_a;
  logic [3:0]    sample_a [NL];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    mux4_scan_ctrl #(.DWELL(dw_of(g))) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .cont    (cont),
      .stop    (stop),
      .ch_mask (ch_mask),
      .y       (y_a[g]),
      .s0      (s0_a[g]),
      .s1      (s1_a[g]),
      .busy    (busy_a[g]),
      .done    (done_a[g]),
      .sample  (sample_a[g])
    );
    assign y_a[g] = (y_mode == 0) ? y_rand :
                    (y_mode == 1) ? 1'b1 : (s1_a[g] ^ s0_a[g]);
  end

  // Frame-schedule model: a frame started at edge e0 visits the enabled
  // channels in ascending order, channel i owning edges e0+i*dw .. e0+(i+1)*dw-1.
  int         t = 0;
  bit         act   [NL];
  int         e0    [NL];
  int         nch   [NL];
  int         chs   [NL][4];
  bit         mcont [NL];
  bit         mstp  [NL];
  logic [3:0] cap   [NL];
  logic [3:0] e_sample [NL];
  logic       e_done [NL];
  logic       e_busy [NL];
  logic [1:0] e_sel  [NL];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input int l, input logic [7:0] a, input logic [7:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, l, $time, a, e);
    end
  endfunction

  function automatic void load(input int l, input logic [3:0] m);
    nch[l] = 0;
    for (int k = 0; k < 4; k++)
      if (m[k]) begin
        chs[l][nch[l]] = k;
        nch[l]++;
      end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NL; l++) begin
        act[l] = 0; mstp[l] = 0; mcont[l] = 0; cap[l] = 4'h0; nch[l] = 0; e0[l] = 0;
        e_sample[l] = 4'h0; e_done[l] = 0; e_busy[l] = 0; e_sel[l] = 2'd0;
      end
    end else begin
      t++;
      for (int l = 0; l < NL; l++) begin
        int dw, rel, idx;
        dw = dw_of(l);
        e_done[l] = 0;
        if (!act[l]) begin
          if (start) begin
            if (ch_mask != 4'h0) begin
              load(l, ch_mask);
              act[l] = 1; e0[l] = t; mcont[l] = cont; cap[l] = 4'h0;
            end else begin
              e_done[l] = 1; e_sample[l] = 4'h0;
            end
          end
        end else begin
          if (stop) mstp[l] = 1;
          rel = t - e0[l];
          if (rel % dw == 0) begin
            idx = rel / dw - 1;
            cap[l][chs[l][idx]] = y_a[l];
            if (idx == nch[l] - 1) begin
              e_sample[l] = cap[l];
              e_done[l]   = 1;
              cap[l]      = 4'h0;
              if (mcont[l] && !mstp[l] && ch_mask != 4'h0) begin
                load(l, ch_mask);
                e0[l] = t;
              end else begin
                act[l] = 0; mstp[l] = 0;
              end
            end
          end
        end
        e_busy[l] = act[l];
        e_sel[l]  = act[l] ? 2'(chs[l][(t - e0[l]) / dw]) : 2'd0;
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      chk("busy",   l, {7'd0, busy_a[l]}, {7'd0, e_busy[l]});
      chk("sel",    l, {6'd0, s1_a[l], s0_a[l]}, {6'd0, e_sel[l]});
      chk("done",   l, {7'd0, done_a[l]}, {7'd0, e_done[l]});
      chk("sample", l, {4'd0, sample_a[l]}, {4'd0, e_sample[l]});
    end
  end

  // Per-frame observations for the hand-computed checks.
  int         lat [NL];
  int         ndone [NL];
  int         dk [NL][2];
  bit         busy_seen [NL];
  logic [3:0] first_s [NL];
  logic [3:0] last_s [NL];

  task automatic frame(input logic [3:0] m, input int hold, input int chg_k,
                       input logic [3:0] m2, input int stp_on, input int stp_off);
    bit idle;
    for (int l = 0; l < NL; l++) begin
      lat[l] = -1; ndone[l] = 0; dk[l][0] = -1; dk[l][1] = -1;
      busy_seen[l] = 0; first_s[l] = 4'hx; last_s[l] = 4'hx;
    end
    ch_mask = m;
    start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == hold)    start = 1'b0;
      if (k == chg_k)   ch_mask = m2;
      if (k == stp_on)  stop = 1'b1;
      if (k == stp_off) stop = 1'b0;
      idle = 1;
      for (int l = 0; l < NL; l++) begin
        if (busy_a[l]) begin
          busy_seen[l] = 1; idle = 0;
        end
        if (done_a[l]) begin
          if (ndone[l] < 2) dk[l][ndone[l]] = k;
          if (ndone[l] == 0) begin
            first_s[l] = sample_a[l]; lat[l] = k;
          end
          last_s[l] = sample_a[l];
          ndone[l]++;
        end
      end
      if (idle && k >= hold) break;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      chk("rst_busy", l, {7'd0, busy_a[l]}, 8'd0);
      chk("rst_sample", l, {4'd0, sample_a[l]}, 8'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Full mask, y = channel parity.
    y_mode = 2;
    frame(4'hF, 1, 0, 4'h0, 0, 0);
    for (int l = 0; l < NL; l++) chk("t1_sample", l, {4'd0, first_s[l]}, 8'h06);
    chk("t1_lat", 0, 8'(lat[0]), 8'd9);
    chk("t1_lat", 1, 8'(lat[1]), 8'd5);
    chk("t1_lat", 2, 8'(lat[2]), 8'd13);

    // Sparse mask, y tied high.
    y_mode = 1;
    frame(4'b1010, 1, 0, 4'h0, 0, 0);
    for (int l = 0; l < NL; l++) chk("t2_sample", l, {4'd0, first_s[l]}, 8'h0A);
    chk("t2_lat", 0, 8'(lat[0]), 8'd5);
    chk("t2_lat", 1, 8'(lat[1]), 8'd3);

    // Empty mask.
    frame(4'h0, 1, 0, 4'h0, 0, 0);
    for (int l = 0; l < NL; l++) begin
      chk("t3_busy_seen", l, {7'd0, busy_seen[l]}, 8'd0);
      chk("t3_lat", l, 8'(lat[l]), 8'd1);
      chk("t3_sample", l, {4'd0, first_s[l]}, 8'd0);
    end

    // Continuous: mask shrinks mid-frame 1, stop during frame 2.
    y_mode = 2;
    cont = 1'b1;
    frame(4'hF, 1, 3, 4'h1, 9, 12);
    cont = 1'b0;
    chk("t4_ndone", 0, 8'(ndone[0]), 8'd2);
    chk("t4_done1_k", 0, 8'(dk[0][0]), 8'd9);
    chk("t4_done2_k", 0, 8'(dk[0][1]), 8'd11);
    chk("t4_sample1", 0, {4'd0, first_s[0]}, 8'h06);
    chk("t4_sample2", 0, {4'd0, last_s[0]}, 8'h00);

    // Reset in the middle of a full-mask frame.
    y_mode = 1;
    frame(4'hF, 1, 0, 4'h0, 0, 0);
    chk("t5_pre_sample", 0, {4'd0, first_s[0]}, 8'h0F);
    y_mode = 2;
    ch_mask = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      chk("t5_rst_busy", l, {7'd0, busy_a[l]}, 8'd0);
      chk("t5_rst_sel", l, {6'd0, s1_a[l], s0_a[l]}, 8'd0);
      chk("t5_rst_done", l, {7'd0, done_a[l]}, 8'd0);
      chk("t5_rst_sample", l, {4'd0, sample_a[l]}, 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame(4'hF, 1, 0, 4'h0, 0, 0);
    chk("t5_sample", 0, {4'd0, first_s[0]}, 8'h06);
    chk("t5_lat", 0, 8'(lat[0]), 8'd9);

    // Start held high during the frame.
    frame(4'hF, 4, 0, 4'h0, 0, 0);
    chk("t6_lat", 1, 8'(lat[1]), 8'd5);
    chk("t6_ndone", 1, 8'(ndone[1]), 8'd1);
    chk("t6_sample", 1, {4'd0, first_s[1]}, 8'h06);

    // Randomized traffic against the model.
    y_mode = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      y_rand  = 1'($urandom);
      start   = ($urandom_range(0, 3) == 0);
      cont    = 1'($urandom);
      stop    = ($urandom_range(0, 15) == 0);
      ch_mask = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    cont  = 1'b0;
    stop  = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Sequencer that sits directly upstream of, and closes the loop around, the `mux4to1` 4:1 selector. It drives the `s1`/`s0` select lines to step through the enabled input channels, waits a programmable dwell time on each, and samples the mux output `y`. When a frame completes it publishes one bit per channel as a 4-bit snapshot with a single-cycle done strobe. It supports single-shot and continuous scanning.

## Interface
Parameters:
- `DWELL`, default 2: clock cycles each channel is held before its capture. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled in IDLE only; begins a frame.
- `cont`  in  1  continuous mode, sampled together with `start`.
- `stop`  in  1  in continuous mode, finish the current frame, then return to IDLE.
- `ch_mask`  in  4  channel enable; bit k enables channel k. Latched at each frame start.
- `y`  in  1  output of the downstream 4:1 mux.
- `s0`, `s1`  out  1 each  registered selects; channel k drives `s1`=k[1] and `s0`=k[0].
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle strobe at the end of each frame.
- `sample`  out  4  last completed snapshot; bit k holds the `y` captured on channel k, or 0 if channel k was disabled.

## Operation
- The FSM has two states, IDLE and SCAN. The dwell counter is `$clog2(DWELL+1)` bits wide. The current channel register is 2 bits.
- **IDLE.** `s1`,`s0`=00 and `busy`=0.
  - On `start`=1 with a non-zero mask:
    - latch `ch_mask` and `cont`;
    - load the channel register with the lowest enabled channel;
    - clear the dwell counter;
    - move to SCAN.
  - On `start`=1 with `ch_mask`=0:
    - stay in IDLE;
    - pulse `done` next cycle;
    - set `sample` to 0.
- **SCAN.**
  - The dwell counter increments each cycle. When it reaches DWELL-1, `y` is written into shadow bit [ch] on the next edge.
  - The channel then advances to the next higher enabled channel, and the counter clears.
  - Channels are visited in ascending order. Disabled channels are skipped with no dwell.
- **End of frame**, on the capture edge of the highest enabled channel:
  - `sample` is loaded from the shadow, with disabled bits forced to 0;
  - `done` goes high for one cycle;
  - the shadow register clears.
  - Then:
    - If `cont`=1 and no stop is pending: re-latch `ch_mask` and restart at its lowest enabled channel on that same edge, so there are no idle cycles. If the re-latched mask is 0, go to IDLE.
    - Otherwise, go to IDLE.
- `stop` is a sticky request. It is set by any `stop`=1 during SCAN and cleared on entry to IDLE.
- `start` during SCAN is ignored. Changes to `ch_mask` mid-frame have no effect until the next frame start.
- `sample` holds its value between frames.
- **Reset (async, any time, including mid-frame):**
  - `s0`=`s1`=0, `busy`=0, `done`=0, `sample`=0;
  - shadow, counter, channel register and stop flag are cleared;
  - FSM goes to IDLE.
  - A partial frame is discarded and never published.

## Timing
- Let E0 be the edge that samples `start`.
  - From E0: selects equal the first enabled channel and `busy`=1.
  - Capture i (i = 1..N, N = number of enabled channels) occurs at edge E0+i·DWELL.
  - `done` and the new `sample` are visible in the cycle after E0+N·DWELL.
- Frame latency is N·DWELL cycles. Full mask with DWELL=2 gives 8 cycles.
- `busy` falls on the same edge that raises `done` (single-shot). In continuous mode `busy` stays high.
- Selects change only on capture edges. `y` must therefore be settled within DWELL cycles of a select change.
- Mask=0 start: `done` is high in the cycle after E0 and `busy` never rises.

## Structure
- Package `mux4_scan_pkg`:
  - state enum {IDLE, SCAN};
  - `NUM_CH`=4;
  - `CH_W`=2.
- Sub-module `mux4_next_ch` (combinational):
  - inputs: mask and current channel;
  - outputs: next higher enabled channel plus a `last` flag;
  - also used for first-channel lookup, with a "none" input.
- Top level contains the FSM, dwell counter, shadow register and output registers.

## Test plan
- Reset, then `start` with `ch_mask`=1111, DWELL=2, `y` = channel index parity (0,1,1,0) → selects step 00,01,10,11 every 2 cycles; `done` in the cycle after E0+8; `sample`=0110.
- `ch_mask`=1010, `y` forced 1 → only channels 1 and 3 are visited; `done` after E0+4; `sample`=1010.
- `start` with `ch_mask`=0000 → `busy` stays 0; `done` pulses once the next cycle; `sample`=0000.
- `cont`=1, mask 1111, `ch_mask` changed to 0001 mid-frame, `stop` asserted in frame 2 → frame 1 is unaffected; frame 2 scans only channel 0 with no gap; IDLE after frame 2 ends; two `done` pulses.
- `rst_n` pulsed low at E0+5 of a full-mask frame → all outputs 0 immediately; no `done`; the next `start` produces a clean frame.
- `start` held high during SCAN, DWELL=1 → no restart mid-frame; one capture per cycle; `done` after E0+4.
